// File: rtl/aes_pkg.sv
// Shared AES types and byte-level helpers used by the iterative cipher core.
// Contents: NB constant, 128-bit state type, S-box lookup, xtime, ShiftRows.
package aes_pkg;

    localparam int unsigned NB      = 4;
    localparam int unsigned BLOCK_W = 128;

    typedef logic [BLOCK_W-1:0] aes_state_t;

    // Forward S-box, entry 0x00 in the MSBs.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Entry b sits at bit offset 8*(255-b); ~b equals 255-b for a byte.
    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_TABLE[{~b, 3'b000} +: 8];
    endfunction

    // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Byte n = row + 4*col lives at [127-8n -: 8]; row r rotates left by r columns.
    function automatic aes_state_t shift_rows(input aes_state_t s);
        aes_state_t r;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int w = 0; w < 4; w++) begin
                r[127-8*(w+4*c) -: 8] = s[127-8*(w+4*((c+w)%4)) -: 8];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/aes_enc_round.sv
// One combinational AES encryption round.
// Ports: i_state (round input), i_round_key, i_final (skip MixColumns),
//        o_state (SubBytes -> ShiftRows -> [MixColumns] -> AddRoundKey).
module aes_enc_round
    import aes_pkg::*;
(
    input  logic [BLOCK_W-1:0] i_state,
    input  logic [BLOCK_W-1:0] i_round_key,
    input  logic               i_final,
    output logic [BLOCK_W-1:0] o_state
);

    aes_state_t sub_c;
    aes_state_t shf_c;
    aes_state_t mix_c;

    function automatic logic [31:0] mix_column(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = col;
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    // SubBytes
    always_comb begin
        sub_c = '0;
        for (int i = 0; i < 16; i++) begin
            sub_c[8*i +: 8] = sbox(i_state[8*i +: 8]);
        end
    end

    assign shf_c = shift_rows(sub_c);

    // MixColumns, one 32-bit column per word
    always_comb begin
        mix_c = '0;
        for (int c = 0; c < NB; c++) begin
            mix_c[127-32*c -: 32] = mix_column(shf_c[127-32*c -: 32]);
        end
    end

    assign o_state = (i_final ? shf_c : mix_c) ^ i_round_key;

endmodule

// File: rtl/aes_cipher_iter.sv
// Iterative AES encryption core: one round per clock, valid/ready on both sides.
// Ports: i_clk, i_rst_n (async, active-low), i_expanded_key (round 0 in MSBs),
//        i_plaintext/i_valid/o_ready (input handshake),
//        o_ciphertext/o_valid/i_ready (output handshake).
module aes_cipher_iter
    import aes_pkg::*;
#(
    parameter int unsigned NK = 4,
    parameter int unsigned NR = 10
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic [128*(NR+1)-1:0]      i_expanded_key,
    input  logic [BLOCK_W-1:0]         i_plaintext,
    input  logic                       i_valid,
    output logic                       o_ready,
    output logic [BLOCK_W-1:0]         o_ciphertext,
    output logic                       o_valid,
    input  logic                       i_ready
);

    localparam int unsigned KEY_W = BLOCK_W * (NR + 1);
    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {IDLE, ROUND, DONE} fsm_t;

    fsm_t             fsm_q, fsm_d;
    aes_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    aes_state_t       round_key_c;
    aes_state_t       round_out_c;
    logic             final_c;

    // Key length and round count must describe the same AES variant.
    if (!((NK == 4 || NK == 6 || NK == 8) && NR == NK + 6)) begin : g_bad_cfg
        $error("aes_cipher_iter: NR must equal NK+6 with NK in {4,6,8}");
    end

    // Round-key mux: IDLE whitens with key 0, otherwise the counter selects.
    always_comb begin
        round_key_c = i_expanded_key[KEY_W-BLOCK_W +: BLOCK_W];
        for (int unsigned r = 1; r <= NR; r++) begin
            if (fsm_q != IDLE && cnt_q == CNT_W'(r)) begin
                round_key_c = i_expanded_key[KEY_W-BLOCK_W*(r+1) +: BLOCK_W];
            end
        end
    end

    assign final_c = (cnt_q == CNT_W'(NR));

    aes_enc_round u_round (
        .i_state     (state_q),
        .i_round_key (round_key_c),
        .i_final     (final_c),
        .o_state     (round_out_c)
    );

    // Next-state logic
    always_comb begin
        fsm_d   = fsm_q;
        state_d = state_q;
        cnt_d   = cnt_q;
        case (fsm_q)
            IDLE: begin
                if (i_valid) begin
                    state_d = i_plaintext ^ round_key_c;
                    cnt_d   = CNT_W'(1);
                    fsm_d   = ROUND;
                end
            end
            ROUND: begin
                state_d = round_out_c;
                if (final_c) begin
                    fsm_d = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                if (i_ready) begin
                    fsm_d = IDLE;
                end
            end
            default: fsm_d = IDLE;
        endcase
    end

    // State and registered handshake outputs
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            fsm_q   <= IDLE;
            state_q <= '0;
            cnt_q   <= '0;
            o_ready <= 1'b1;
            o_valid <= 1'b0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            o_ready <= (fsm_d == IDLE);
            o_valid <= (fsm_d == DONE);
        end
    end

    assign o_ciphertext = state_q;

endmodule

// File: tb/tb_aes_cipher_iter.sv
// Self-checking bench for aes_cipher_iter: FIPS-197 vectors on NR=10 and NR=14
// instances, back-pressure, mid-block reset and back-to-back streaming.
module tb_aes_cipher_iter;

    localparam int unsigned KW10 = 128 * 11;
    localparam int unsigned KW14 = 128 * 15;

    localparam logic [255:0] KEY_B  = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [255:0] KEY_C1 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    localparam logic [127:0] PT_C   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [255:0] KEY_C3 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] CT_C3  = 128'h8ea2b7ca516745bfeafc49904b496089;

    typedef struct {
        logic [255:0] key;
        logic [127:0] pt;
        logic [127:0] ct;
        int           hold;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [KW10-1:0] ek10;
    logic [127:0]    pt10, ct10;
    logic            valid10, ready10, ovalid10, oready10;
    logic [KW14-1:0] ek14;
    logic [127:0]    pt14, ct14;
    logic            valid14, ready14, ovalid14, oready14;

    aes_cipher_iter #(.NK(4), .NR(10)) u_dut10 (
        .i_clk(clk), .i_rst_n(rst_n), .i_expanded_key(ek10), .i_plaintext(pt10),
        .i_valid(valid10), .o_ready(oready10), .o_ciphertext(ct10),
        .o_valid(ovalid10), .i_ready(ready10)
    );

    aes_cipher_iter #(.NK(8), .NR(14)) u_dut14 (
        .i_clk(clk), .i_rst_n(rst_n), .i_expanded_key(ek14), .i_plaintext(pt14),
        .i_valid(valid14), .o_ready(oready14), .o_ciphertext(ct14),
        .o_valid(ovalid14), .i_ready(ready14)
    );

    int           checks = 0;
    int           errors = 0;
    int           n_accept = 0;
    int           cyc = 0;
    logic [127:0] cur_exp = '0;
    logic [127:0] exp_q[$];
    vec_t         vecs[3];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference GF(2^8) arithmetic and S-box derived from the field inverse.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] ref_sbox(input logic [7:0] a);
        logic [7:0] inv = 8'h00;
        for (int b = 1; b < 256; b++) begin
            if (gmul(a, 8'(b)) == 8'h01) inv = 8'(b);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] t);
        return {ref_sbox(t[31:24]), ref_sbox(t[23:16]), ref_sbox(t[15:8]), ref_sbox(t[7:0])};
    endfunction

    // Key schedule; words packed from the MSB, key left-aligned in 256 bits.
    function automatic logic [KW14-1:0] expand_key(input logic [255:0] key, input int nk);
        logic [31:0]     w[60];
        logic [31:0]     t;
        logic [7:0]      rc = 8'h01;
        logic [KW14-1:0] res = '0;
        int              nr = nk + 6;
        for (int i = 0; i < 4 * (nr + 1); i++) begin
            if (i < nk) begin
                w[i] = key[255-32*i -: 32];
            end else begin
                t = w[i-1];
                if (i % nk == 0) begin
                    t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                    rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
                end else if (nk > 6 && i % nk == 4) begin
                    t = sub_word(t);
                end
                w[i] = w[i-nk] ^ t;
            end
            res[KW14-1-32*i -: 32] = w[i];
        end
        return res;
    endfunction

    // Scoreboard: push on input handshake, pop and compare on output handshake.
    always @(negedge clk) begin
        if (rst_n) begin
            if (oready10 && valid10) begin
                exp_q.push_back(cur_exp);
                n_accept++;
            end
            if (ovalid10 && ready10) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected_output: got %h with empty queue", ct10);
                end else begin
                    check("sb_ciphertext", ct10, exp_q.pop_front());
                end
            end
        end
    end

    task automatic load_key10(input logic [255:0] key);
        logic [KW14-1:0] ekf;
        ekf  = expand_key(key, 4);
        ek10 = ekf[KW14-1 -: KW10];
    endtask

    // One block on the NR=10 core with hold cycles of output back-pressure.
    task automatic run_vec(input vec_t v, input string tag);
        int   n;
        int   acc0;
        logic seen;
        @(posedge clk); #1;
        load_key10(v.key);
        pt10 = v.pt; cur_exp = v.ct; ready10 = (v.hold == 0); valid10 = 1'b1;
        acc0 = n_accept;
        @(negedge clk);
        check({tag, "_ready_idle"}, 128'(oready10), 128'(1));
        @(posedge clk); #1;
        valid10 = 1'b0;
        pt10 = {$urandom, $urandom, $urandom, $urandom};
        n = 0; seen = 1'b0;
        while (!seen && n < 40) begin
            @(negedge clk);
            n++;
            seen = ovalid10;
        end
        check({tag, "_latency"}, 128'(n), 128'(11));
        if (v.hold == 0) begin
            @(posedge clk); #1 ready10 = 1'b0;
        end else begin
            for (int k = 0; k < v.hold; k++) begin
                @(posedge clk); #1;
                valid10 = ~valid10;
                pt10 = {$urandom, $urandom, $urandom, $urandom};
                @(negedge clk);
                check({tag, "_hold_valid"}, 128'(ovalid10), 128'(1));
                check({tag, "_hold_ready"}, 128'(oready10), 128'(0));
                check({tag, "_hold_ct"}, ct10, v.ct);
            end
            @(posedge clk); #1 valid10 = 1'b0; ready10 = 1'b1;
            @(posedge clk); #1 ready10 = 1'b0;
        end
        @(negedge clk);
        check({tag, "_valid_drop"}, 128'(ovalid10), 128'(0));
        check({tag, "_ready_back"}, 128'(oready10), 128'(1));
        check({tag, "_ct_kept"}, ct10, v.ct);
        check({tag, "_accepts"}, 128'(n_accept - acc0), 128'(1));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int              n;
        int              t1;
        int              t2;
        int              acc0;
        logic            seen;
        logic [KW14-1:0] ekf;

        vecs[0] = '{key: KEY_B,  pt: PT_B, ct: CT_B,  hold: 0};
        vecs[1] = '{key: KEY_C1, pt: PT_C, ct: CT_C1, hold: 3};
        vecs[2] = '{key: KEY_B,  pt: PT_B, ct: CT_B,  hold: 20};

        rst_n = 1'b0;
        ek10 = '0; pt10 = '0; valid10 = 1'b0; ready10 = 1'b0;
        ek14 = '0; pt14 = '0; valid14 = 1'b0; ready14 = 1'b0;

        // Reset values
        @(negedge clk);
        check("rst_valid10", 128'(ovalid10), 128'(0));
        check("rst_ready10", 128'(oready10), 128'(1));
        check("rst_ct10", ct10, 128'h0);
        check("rst_valid14", 128'(ovalid14), 128'(0));
        check("rst_ready14", 128'(oready14), 128'(1));
        @(posedge clk); #1 rst_n = 1'b1;

        // Table-driven vectors on the NR=10 core
        for (int i = 0; i < 3; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // FIPS-197 C.3 on the NR=14 core
        @(posedge clk); #1;
        ekf = expand_key(KEY_C3, 8);
        ek14 = ekf; pt14 = PT_C; valid14 = 1'b1; ready14 = 1'b0;
        @(negedge clk);
        check("c3_ready_idle", 128'(oready14), 128'(1));
        @(posedge clk); #1 valid14 = 1'b0;
        n = 0; seen = 1'b0;
        while (!seen && n < 40) begin
            @(negedge clk);
            n++;
            seen = ovalid14;
        end
        check("c3_latency", 128'(n), 128'(15));
        check("c3_ct", ct14, CT_C3);
        check("c3_ready_busy", 128'(oready14), 128'(0));
        @(posedge clk); #1 ready14 = 1'b1;
        @(posedge clk); #1 ready14 = 1'b0;
        @(negedge clk);
        check("c3_valid_drop", 128'(ovalid14), 128'(0));
        check("c3_ready_back", 128'(oready14), 128'(1));

        // Asynchronous reset during round 5 of App.B
        @(posedge clk); #1;
        load_key10(KEY_B);
        pt10 = PT_B; cur_exp = CT_B; ready10 = 1'b1; valid10 = 1'b1;
        @(posedge clk); #1 valid10 = 1'b0;
        repeat (4) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("abort_valid", 128'(ovalid10), 128'(0));
        check("abort_ready", 128'(oready10), 128'(1));
        check("abort_ct", ct10, 128'h0);
        exp_q.delete();
        @(negedge clk);
        check("abort_hold_valid", 128'(ovalid10), 128'(0));
        check("abort_hold_ready", 128'(oready10), 128'(1));
        @(posedge clk); #1 rst_n = 1'b1; ready10 = 1'b0;
        run_vec(vecs[0], "after_abort");

        // Back-to-back streaming: C.1 then App.B with valid and ready held high
        @(posedge clk); #1;
        load_key10(KEY_C1);
        pt10 = PT_C; cur_exp = CT_C1; ready10 = 1'b1; valid10 = 1'b1;
        acc0 = n_accept;
        n = 0; seen = 1'b0;
        while (!seen && n < 40) begin
            @(negedge clk);
            n++;
            seen = ovalid10;
        end
        t1 = cyc;
        check("stream_first_done", 128'(seen), 128'(1));
        @(posedge clk); #1;
        load_key10(KEY_B);
        pt10 = PT_B; cur_exp = CT_B;
        @(negedge clk);
        check("stream_ready_after_hs", 128'(oready10), 128'(1));
        n = 0; seen = 1'b0;
        while (!seen && n < 40) begin
            @(negedge clk);
            n++;
            seen = ovalid10;
        end
        t2 = cyc;
        check("stream_period", 128'(t2 - t1), 128'(12));
        @(posedge clk); #1 valid10 = 1'b0;
        @(posedge clk); #1 ready10 = 1'b0;
        @(negedge clk);
        check("stream_accepts", 128'(n_accept - acc0), 128'(2));
        check("stream_ready_end", 128'(oready10), 128'(1));

        check("sb_queue_empty", 128'(exp_q.size()), 128'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/aes_cipher_iter.md
Name: aes_cipher_iter

Overview:
- Iterative AES encryption core. Sits directly downstream of key_expansion and consumes its o_expanded_key bus.
- Encrypts one 128-bit block per transaction, one round per clock, using the round keys sliced from the expanded key.
- Valid/ready handshake on the input and output sides, so the core can sit in a streaming datapath.
- Supports AES-128/192/256 through the same NK/NR pair used by key_expansion.

Parameters:
- NK, 4, key length in 32-bit words (4/6/8); informational, kept for instantiation symmetry with key_expansion.
- NR, 10, number of rounds (10/12/14); sets the expanded-key width 128*(NR+1) and the round counter range.

Ports:
- i_clk  input  1  clock; all state updates on the rising edge.
- i_rst_n  input  1  reset; asynchronous, active-low.
- i_expanded_key  input  128*(NR+1)  round keys, round 0 in the MSBs. Round key r = bits [128*(NR+1)-1-128*r -: 128].
- i_plaintext  input  128  input block, FIPS-197 byte order (byte 0 at [127:120], column-major).
- i_valid  input  1  i_plaintext is valid.
- o_ready  output  1  core can accept a block.
- o_ciphertext  output  128  encrypted block; valid while o_valid is high.
- o_valid  output  1  o_ciphertext is valid.
- i_ready  input  1  downstream accepts the output.

Behaviour:
- Reset (async, i_rst_n=0):
  - FSM goes to IDLE; state register, round counter and o_ciphertext clear to 0.
  - o_valid=0, o_ready=1. These hold while reset is asserted.
- FSM states: IDLE, ROUND, DONE. o_ready = (FSM==IDLE); o_valid = (FSM==DONE).
- IDLE:
  - On an edge with i_valid=1: state <= i_plaintext ^ rk[0], cnt <= 1, go to ROUND.
  - Otherwise hold.
- ROUND, cnt < NR: state <= MixColumns(ShiftRows(SubBytes(state))) ^ rk[cnt], cnt <= cnt+1.
- ROUND, cnt == NR (final round):
  - state <= ShiftRows(SubBytes(state)) ^ rk[NR], with no MixColumns.
  - Go to DONE.
- DONE:
  - o_ciphertext = state, o_valid=1.
  - On an edge with i_ready=1, go to IDLE. o_ciphertext keeps its last value, but o_valid drops.
- Latency: accept edge = A. o_valid first rises after edge A+NR, so NR+1 cycles from accept to the first valid cycle.
- Throughput:
  - Next accept happens no earlier than the edge after the output handshake edge.
  - Minimum 1 block per NR+2 cycles.
- cnt width is 4 bits, sufficient for NR ≤ 14. cnt never exceeds NR and never wraps.
- Key stability: the core does not register i_expanded_key. Upstream holds it stable from the accept edge through the final round; a change mid-block gives undefined ciphertext.
- i_plaintext is only sampled on the accept edge. Changes while in ROUND or DONE are ignored.
- i_valid while not in IDLE is ignored (o_ready=0). No input is dropped silently, because the handshake was never completed.
- i_ready in IDLE or ROUND: no effect.
- Back-pressure: DONE holds indefinitely with o_valid=1 and o_ciphertext stable until i_ready=1.
- Reset mid-block (ROUND or DONE): immediate abort. Outputs return to reset values; no partial result is emitted.
- Simultaneous i_valid and i_ready while in DONE: only the output handshake completes. The input is not accepted until IDLE.

Decomposition:
- aes_pkg holds:
  - the constant NB=4 and a 128-bit state typedef;
  - the S-box lookup function;
  - the xtime (GF(2^8) multiply-by-2) function;
  - the ShiftRows byte permutation function.
- Sub-module aes_enc_round (combinational):
  - inputs: state, round key, i_final;
  - output: next state;
  - datapath: 16 S-boxes, ShiftRows, MixColumns bypassed when i_final=1, AddRoundKey.
- aes_cipher_iter holds only the FSM, the counter, the round-key mux and the registers.

Test Plan:
- Each scenario instantiates the existing key_expansion to drive i_expanded_key.
- FIPS-197 App.B, NK=4/NR=10:
  - Stimulus: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734.
  - Required response: o_ciphertext 3925841d02dc09fbdc118597196a0b32; o_valid rises exactly 11 cycles after accept.
- FIPS-197 C.1, NK=4:
  - Stimulus: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff.
  - Required response: ct 69c4e0d86a7b0430d8cdb78070b4c55a.
- FIPS-197 C.3, NK=8/NR=14:
  - Stimulus: key 000102…1e1f, same pt.
  - Required response: ct 8ea2b7ca516745bfeafc49904b496089; o_valid rises 15 cycles after accept.
- Back-pressure:
  - Stimulus: hold i_ready=0 for 20 cycles after o_valid rises; toggle i_valid and i_plaintext meanwhile.
  - Required response: o_valid stays 1, ct unchanged, o_ready stays 0, no second accept.
- Reset mid-block:
  - Stimulus: assert i_rst_n=0 asynchronously (between edges) at round 5 of the App.B vector.
  - Required response: o_valid=0, o_ready=1 and o_ciphertext=0 immediately. After release, the App.B vector re-run gives 3925841d….
- Back-to-back streaming with i_valid and i_ready held at 1:
  - Stimulus: C.1 then App.B blocks.
  - Required response: both cts correct, in order; second accept occurs on the edge after the first output handshake; period 12 cycles for NR=10.
